key_event_queue: RTL

KEY_EVENT_QUEUE -- requirements
Module: key_event_queue

---
 rtl/key_event_queue.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/key_event_queue.sv
// Debounced five-button front end with auto-repeat and a small event FIFO.
// Events: 1 LEFT, 2 RIGHT, 3 ROTATE, 4 DROP, 5 NEW_GAME.
module key_event_queue #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 15000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       btn_left_i,
  input  logic       btn_right_i,
  input  logic       btn_up_i,
  input  logic       btn_down_i,
  input  logic       btn_new_game_i,
  input  logic       user_event_rd_req_i,
  output logic [2:0] user_event_o,
  output logic       user_event_ready_o,
  output logic       overflow_o
);

  localparam int NB   = 5;
  localparam int CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                        REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TW   = $clog2(RMAX + 1);
  localparam int PW   = $clog2(FIFO_DEPTH);

  // Bit i carries event code i+1; only LEFT, RIGHT and DROP repeat.
  localparam logic [NB-1:0] RPT_EN = 5'b01011;

  logic [NB-1:0] raw;
  logic [NB-1:0] sync1;
  logic [NB-1:0] sync2;
  logic [NB-1:0] deb;
  logic [NB-1:0] pend;
  logic [NB-1:0] first;
  logic [CW-1:0] cnt [NB];
  logic [TW-1:0] tmr [NB];

  logic [NB-1:0] rise;
  logic [NB-1:0] fall;
  logic [NB-1:0] rpt;
  logic [NB-1:0] set;
  logic [NB-1:0] sel;
  logic [NB-1:0] clr;
  logic [2:0]    code_in;

  logic [2:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [PW:0]   count;
  logic          ovf;
  logic          empty;
  logic          full;
  logic          pop;
  logic          push;
  logic          drop;

  assign raw = {btn_new_game_i, btn_down_i, btn_up_i,
                btn_right_i, btn_left_i};

  always_comb begin
    rise = '0;
    fall = '0;
    rpt  = '0;
    for (int i = 0; i < NB; i++) begin
      logic hit;
      logic [TW-1:0] lim;
      hit = (sync2[i] != deb[i]) &&
            (cnt[i] == CW'(DEBOUNCE_CYCLES - 1));
      rise[i] = hit && !deb[i];
      fall[i] = hit && deb[i];
      lim = first[i] ? TW'(REPEAT_DELAY - 1) :
                       TW'(REPEAT_PERIOD - 1);
      // A falling level in this cycle suppresses any due repeat.
      rpt[i] = RPT_EN[i] && deb[i] && !fall[i] &&
               (tmr[i] == lim);
    end
    set = rise | rpt;
  end

  always_comb begin
    sel     = '0;
    code_in = 3'd0;
    priority case (1'b1)
      pend[4]: begin sel[4] = 1'b1; code_in = 3'd5; end
      pend[3]: begin sel[3] = 1'b1; code_in = 3'd4; end
      pend[2]: begin sel[2] = 1'b1; code_in = 3'd3; end
      pend[0]: begin sel[0] = 1'b1; code_in = 3'd1; end
      pend[1]: begin sel[1] = 1'b1; code_in = 3'd2; end
      default: begin sel = '0; code_in = 3'd0; end
    endcase
  end

  assign empty = (count == '0);
  assign full  = (count == (PW+1)'(FIFO_DEPTH));
  assign pop   = user_event_rd_req_i && !empty;
  assign push  = (|pend) && (!full || pop);
  assign drop  = (|pend) && full && !pop;
  assign clr   = (push || drop) ? sel : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      pend  <= '0;
      first <= '0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      ovf   <= 1'b0;
      for (int i = 0; i < NB; i++) begin
        cnt[i] <= '0;
        tmr[i] <= '0;
      end
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < NB; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          deb[i] <= ~deb[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
        if (rise[i]) begin
          tmr[i]   <= '0;
          first[i] <= 1'b1;
        end else if (rpt[i]) begin
          tmr[i]   <= '0;
          first[i] <= 1'b0;
        end else if (RPT_EN[i] && deb[i] && !fall[i]) begin
          tmr[i] <= tmr[i] + TW'(1);
        end else begin
          tmr[i] <= '0;
        end
      end
      pend <= (pend & ~clr) | set;
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      if (push && !pop)      count <= count + (PW+1)'(1);
      else if (pop && !push) count <= count - (PW+1)'(1);
      if (drop) ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && push) mem[wptr] <= code_in;
  end

  assign user_event_ready_o = !rst_i && !empty;
  assign user_event_o       = user_event_ready_o ? mem[rptr] : 3'd0;
  assign overflow_o         = !rst_i && ovf;

endmodule
